// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
// Optional burst lock is built only when DMEM_ARB_LOCK_EN is defined.
package dmem_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_EXT  = 2'd2
   } owner_e;

   // Default starvation limit; legal range 1..15 so it fits the counter.
   localparam int STARVE_MAX_DEF = 4;
   localparam int CNT_W          = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core, the external master, the data memory and dmem_arbiter.
// ext_lock exists only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   // Core side: no handshake, the core owns memory unless core_stall is raised.
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;

   // External side: ext_req is the valid, ext_gnt the ready. The master holds
   // ext_req and its fields stable until ext_gnt; the transfer happens on the
   // rising edge where both are high. Reads return ext_rdata with a
   // one-cycle ext_rvalid pulse after that edge.
   logic              ext_req;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
`ifdef DMEM_ARB_LOCK_EN
   logic              ext_lock;
`endif
   logic              ext_gnt;
   logic [DATA_W-1:0] ext_rdata;
   logic              ext_rvalid;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   dmem_arb_pkg::arb_state_e           state_dbg;
   logic [dmem_arb_pkg::CNT_W-1:0]     starve_cnt_dbg;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  ext_req, ext_we, ext_addr, ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
      input  ext_lock,
`endif
      input  mem_rdata,
      output core_rdata, core_stall,
      output ext_gnt, ext_rdata, ext_rvalid,
      output mem_we, mem_addr, mem_wdata,
      output state_dbg, starve_cnt_dbg
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output ext_req, ext_we, ext_addr, ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
      output ext_lock,
`endif
      output mem_rdata,
      input  core_rdata, core_stall,
      input  ext_gnt, ext_rdata, ext_rvalid,
      input  mem_we, mem_addr, mem_wdata,
      input  state_dbg, starve_cnt_dbg
   );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of cycles the external master has been denied memory.
module dmem_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int MAX = STARVE_MAX_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             at_max
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_W'(MAX))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt    = cnt_q;
   assign at_max = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core has same-cycle priority, external master
// wins after STARVE_MAX denials. Burst lock state built with DMEM_ARB_LOCK_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          CLK,
   input  logic          RESET,
   dmem_arbiter_if.slave bus
);

   arb_state_e        state_q;
   arb_state_e        state_d;
   owner_e            owner;
   logic              ext_gnt;
   logic              core_stall;
   logic              starve_inc;
   logic              starve_clr;
   logic              starve_at_max;
   logic [CNT_W-1:0]  starve_cnt;

   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic [DATA_W-1:0] core_rdata_d;

   logic [DATA_W-1:0] ext_rdata_q;
   logic [DATA_W-1:0] ext_rdata_d;
   logic              ext_rvalid_q;
   logic              ext_rvalid_d;

   dmem_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .CLK    (CLK),
      .RESET  (RESET),
      .inc    (starve_inc),
      .clr    (starve_clr),
      .cnt    (starve_cnt),
      .at_max (starve_at_max)
   );

   // Ownership and next state; everything is forced quiet while RESET is low.
   always_comb begin
      state_d    = state_q;
      owner      = OWN_NONE;
      ext_gnt    = 1'b0;
      core_stall = 1'b0;
      if (RESET) begin
         case (state_q)
            ARB: begin
               if (bus.core_req && bus.ext_req) begin
                  if (starve_at_max) begin
                     owner      = OWN_EXT;
                     ext_gnt    = 1'b1;
                     core_stall = 1'b1;
                  end else begin
                     owner = OWN_CORE;
                  end
               end else if (bus.core_req) begin
                  owner = OWN_CORE;
               end else if (bus.ext_req) begin
                  owner   = OWN_EXT;
                  ext_gnt = 1'b1;
               end
`ifdef DMEM_ARB_LOCK_EN
               if (ext_gnt && bus.ext_lock) begin
                  state_d = LOCKED;
               end
`endif
            end
`ifdef DMEM_ARB_LOCK_EN
            LOCKED: begin
               // The cycle that drops ext_lock is still owned by ext.
               owner      = OWN_EXT;
               ext_gnt    = bus.ext_req;
               core_stall = bus.core_req;
               if (!bus.ext_lock) begin
                  state_d = ARB;
               end
            end
`endif
            default: begin
               state_d = ARB;
            end
         endcase
      end
   end

   always_comb begin
      starve_inc = bus.ext_req && !ext_gnt;
      starve_clr = !bus.ext_req || ext_gnt || (state_q == LOCKED);
   end

   // Memory mux: idle cycles present the core's address with no write.
   always_comb begin
      mem_we_d     = 1'b0;
      mem_addr_d   = bus.core_addr;
      mem_wdata_d  = bus.core_wdata;
      core_rdata_d = '0;
      case (owner)
         OWN_CORE: begin
            mem_we_d     = bus.core_we;
            core_rdata_d = bus.mem_rdata;
         end
         OWN_EXT: begin
            mem_we_d    = bus.ext_we && ext_gnt;
            mem_addr_d  = bus.ext_addr;
            mem_wdata_d = bus.ext_wdata;
         end
         default: begin
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      ext_rvalid_d = ext_gnt && !bus.ext_we;
      ext_rdata_d  = ext_rvalid_d ? bus.mem_rdata : ext_rdata_q;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= ARB;
         ext_rdata_q  <= '0;
         ext_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ext_rdata_q  <= ext_rdata_d;
         ext_rvalid_q <= ext_rvalid_d;
      end
   end

   assign bus.core_rdata     = core_rdata_d;
   assign bus.core_stall     = core_stall;
   assign bus.ext_gnt        = ext_gnt;
   assign bus.ext_rdata      = ext_rdata_q;
   assign bus.ext_rvalid     = ext_rvalid_q;
   assign bus.mem_we         = mem_we_d;
   assign bus.mem_addr       = mem_addr_d;
   assign bus.mem_wdata      = mem_wdata_d;
   assign bus.state_dbg      = state_q;
   assign bus.starve_cnt_dbg = starve_cnt;

endmodule
